// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

  localparam int EDGE_W = 6;
  localparam int BIT_W  = 4;

  localparam logic [EDGE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [EDGE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [EDGE_W-1:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Anything other than 16 or 32 runs at 8x oversampling.
  function automatic logic [EDGE_W-1:0] legal_prescale(input logic [EDGE_W-1:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Line, checker and datapath-control signals between the RX controller and its surroundings.
interface uart_rx_fsm_if;
  import uart_rx_pkg::*;

  logic              rx_in;
  logic              par_en;
  logic [EDGE_W-1:0] prescale;
  logic              strt_glitch;
  logic              par_error;
  logic              stop_error;
  logic [EDGE_W-1:0] edge_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              dat_samp_en;
  logic              strt_chk_en;
  logic              par_chk_en;
  logic              stop_check_en;
  logic              deser_en;
  logic              data_valid;
  logic              frame_err;

  modport master (
    output rx_in, par_en, prescale, strt_glitch, par_error, stop_error,
    input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en,
           stop_check_en, deser_en, data_valid, frame_err
  );

  modport slave (
    input  rx_in, par_en, prescale, strt_glitch, par_error, stop_error,
    output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en,
           stop_check_en, deser_en, data_valid, frame_err
  );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and bit counter; the ratio is latched once per frame.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_latch,
  input  logic [EDGE_W-1:0] i_prescale,
  output logic [EDGE_W-1:0] o_edge_cnt,
  output logic [BIT_W-1:0]  o_bit_cnt,
  output logic              o_last_edge
);

  logic [EDGE_W-1:0] r_p;
  logic [EDGE_W-1:0] r_edge;
  logic [BIT_W-1:0]  r_bit;
  logic [EDGE_W-1:0] w_p_last;

  assign w_p_last    = r_p - EDGE_W'(1);
  assign o_last_edge = (r_edge == w_p_last);
  assign o_edge_cnt  = r_edge;
  assign o_bit_cnt   = r_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p    <= PRESCALE_8;
      r_edge <= '0;
      r_bit  <= '0;
    end else begin
      if (i_latch) begin
        r_p <= legal_prescale(i_prescale);
      end
      if (i_clr) begin
        r_edge <= '0;
        r_bit  <= '0;
      end else if (i_en) begin
        if (o_last_edge) begin
          r_edge <= '0;
          r_bit  <= r_bit + BIT_W'(1);
        end else begin
          r_edge <= r_edge + EDGE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detection, phase sequencing, checker enables and result pulses.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_fsm_if.slave bus
);

  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_WIDTH);

  rx_state_t r_state;
  logic      r_par_err;
  logic      r_data_valid;
  logic      r_frame_err;

  logic      w_last_edge;
  logic      w_idle;
  logic      w_start_det;
  logic      w_to_idle;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_start_det = w_idle && !bus.rx_in;
  // Counters clear whenever the next state is IDLE so a back-to-back start sees edge 0.
  assign w_to_idle   = (w_idle && bus.rx_in)
                    || (r_state == ST_START && w_last_edge && bus.strt_glitch)
                    || (r_state == ST_STOP  && w_last_edge);

  uart_rx_edge_bit_counter u_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_en        (!w_idle || w_start_det),
    .i_clr       (w_to_idle),
    .i_latch     (w_start_det),
    .i_prescale  (bus.prescale),
    .o_edge_cnt  (bus.edge_cnt),
    .o_bit_cnt   (bus.bit_cnt),
    .o_last_edge (w_last_edge)
  );

  assign bus.dat_samp_en   = !w_idle;
  assign bus.strt_chk_en   = (r_state == ST_START)  && w_last_edge;
  assign bus.deser_en      = (r_state == ST_DATA)   && w_last_edge;
  assign bus.par_chk_en    = (r_state == ST_PARITY) && w_last_edge;
  assign bus.stop_check_en = (r_state == ST_STOP)   && w_last_edge;
  assign bus.data_valid    = r_data_valid;
  assign bus.frame_err     = r_frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_par_err    <= 1'b0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_par_err <= 1'b0;
          if (!bus.rx_in) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_last_edge) begin
            r_state <= bus.strt_glitch ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_last_edge && bus.bit_cnt == LAST_DATA_BIT) begin
            r_state <= bus.par_en ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (w_last_edge) begin
            r_par_err <= bus.par_error;
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_last_edge) begin
            if (bus.stop_error || r_par_err) begin
              r_frame_err <= 1'b1;
            end else begin
              r_data_valid <= 1'b1;
            end
            r_par_err <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-path controller for the UART RX. It detects the start bit, runs the per-bit oversampling edge counter and bit counter, and sequences the start/data/parity/stop phases. It drives the sampler, deserializer and the three checkers (start, parity, stop), then reads their error flags back in the same cycle. It issues a single-cycle `data_valid` for a good frame or `frame_err` for a bad one.

## Interface
- `data_width`, 8: data bits per frame.
- `clk` in 1: receive clock, oversampling rate.
- `rst` in 1: asynchronous reset, active-high.
- `rx_in` in 1: serial line; idle high.
- `par_en` in 1: frame carries a parity bit.
- `prescale` in 6: oversampling ratio. 8, 16 and 32 are legal; any other value is treated as 8.
- `strt_glitch` in 1: start checker result; valid while `strt_chk_en`=1.
- `par_error` in 1: parity checker result; valid while `par_chk_en`=1.
- `stop_error` in 1: stop checker result; valid while `stop_check_en`=1.
- `edge_cnt` out 6: oversample index within the current bit, 0..prescale-1.
- `bit_cnt` out 4: bit index within the frame. 0 = start, 1..data_width = data.
- `dat_samp_en` out 1: sampler enable.
- `strt_chk_en`, `par_chk_en`, `stop_check_en` out 1 each: checker enables.
- `deser_en` out 1: shift the sampled bit into the deserializer.
- `data_valid` out 1: one-cycle pulse, frame accepted.
- `frame_err` out 1: one-cycle pulse, frame rejected (parity or stop error).

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- "Last edge" means `edge_cnt` = P-1, where P is the latched prescale.
- Counting:
  - `edge_cnt` and `bit_cnt` are held at 0 in IDLE.
  - Outside IDLE, `edge_cnt` increments every cycle and wraps from P-1 to 0.
  - `bit_cnt` increments on each wrap.
- Prescale latch: `prescale` is captured into P only in the cycle that leaves IDLE. Changes mid-frame have no effect until the next frame.
- IDLE: if `rx_in`=0, go to START. That detection cycle counts as edge 0, so the first cycle in START shows `edge_cnt`=1.
- START: at the last edge, assert `strt_chk_en`.
  - `strt_glitch`=1: go to IDLE. No pulse is issued.
  - Otherwise: go to DATA.
- DATA: assert `deser_en` at each last edge. On the last edge of data bit `data_width`:
  - go to PARITY if `par_en`=1;
  - otherwise go to STOP.
- PARITY: assert `par_chk_en` at the last edge. Register `par_error` into an internal error flag, then go to STOP.
- STOP: assert `stop_check_en` at the last edge.
  - If `stop_error`=1 or the parity flag is set, pulse `frame_err` on the next cycle.
  - Otherwise pulse `data_valid` on the next cycle.
  - Go to IDLE in either case. The parity flag clears on entry to IDLE.
- `par_en` is sampled when leaving DATA; toggling it mid-frame has no effect on the current frame.
- `dat_samp_en`=1 in every state except IDLE.
- `data_valid` and `frame_err` are never high together.
- Back-to-back frames: if `rx_in`=0 in the first IDLE cycle after STOP, that cycle is the new frame's edge 0.
- Reset (asynchronous, at any point including mid-frame): state returns to IDLE and every output goes to 0.

## Timing
- Reset value of every output: 0.
- Checker enables and `deser_en` are Moore decodes of state plus `edge_cnt`. They are high exactly one cycle per bit.
- Error inputs are combinational from the checkers and are consumed in the same cycle as their enable.
- `data_valid` and `frame_err` are registered: they appear one cycle after the STOP last edge.
- Frame length, with detection at cycle 0: (2 + data_width + par_en) × P cycles. The result pulse is at that cycle number.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum;
  - the `PRESCALE_8`, `PRESCALE_16` and `PRESCALE_32` constants;
  - the edge/bit counter widths.
- Sub-module `uart_rx_edge_bit_counter` holds the P latch, the edge wrap and the bit increment. Enable and clear are driven by the FSM.
- The FSM itself is a single next-state process plus registered outputs.

## Test plan
- P=8, `par_en`=1, data 0xA5, correct parity and stop:
  - START occupies cycles 0-7, DATA 8-71, PARITY 72-79, STOP 80-87.
  - `data_valid`=1 at cycle 88 only.
  - `deser_en` fires exactly 8 times.
- P=16, `par_en`=0, data 0x3C, stop bit low: `stop_check_en` at cycle 159, then `frame_err` at 160. No `data_valid`.
- P=8, `par_en`=1, `par_error` forced at cycle 79 with a good stop: `frame_err` at 88. The following good frame gives `data_valid`, which shows the error flag cleared.
- Start glitch: `rx_in` low for 2 cycles and `strt_glitch`=1 at cycle 7. Return to IDLE at cycle 8, counters at 0, no pulses.
- Reset mid-DATA at cycle 30 (P=8): all outputs are 0 immediately. A new frame started after reset is received correctly.
- `prescale` changed from 8 to 32 at cycle 20: the current frame completes with P=8 and the next frame uses P=32. An illegal value (12) behaves as P=8.
